// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and ALU op-select types for the MIPS EX-stage ALU
package mips_pkg;

    localparam logic [5:0] OPC_R     = 6'd0;
    localparam logic [5:0] OPC_ADDI  = 6'd8;
    localparam logic [5:0] OPC_ADDIU = 6'd9;
    localparam logic [5:0] OPC_SLTI  = 6'd10;
    localparam logic [5:0] OPC_SLTIU = 6'd11;
    localparam logic [5:0] OPC_ANDI  = 6'd12;
    localparam logic [5:0] OPC_ORI   = 6'd13;
    localparam logic [5:0] OPC_XORI  = 6'd14;
    localparam logic [5:0] OPC_LUI   = 6'd15;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_SLLV = 6'd4;
    localparam logic [5:0] FN_SRLV = 6'd6;
    localparam logic [5:0] FN_SRAV = 6'd7;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    typedef enum logic [3:0] {
        OP_ZERO, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        BSEL_REG, BSEL_SEXT, BSEL_ZEXT
    } bsel_e;

    typedef enum logic {
        SHSRC_SHAMT, SHSRC_RS
    } shsrc_e;

    typedef struct packed {
        alu_op_e op;
        shsrc_e  shsrc;
    } alu_sel_t;

    localparam alu_sel_t SEL_ZERO = '{op: OP_ZERO, shsrc: SHSRC_SHAMT};

    // Immediate extension depends only on the opcode, so EX can derive it even when op-select is predecoded.
    function automatic bsel_e imm_bsel(input logic [5:0] opc);
        bsel_e b;
        b = BSEL_REG;
        case (opc)
            OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU, OPC_LW, OPC_SW: b = BSEL_SEXT;
            OPC_ANDI, OPC_ORI, OPC_XORI:                             b = BSEL_ZEXT;
            default:                                                 b = BSEL_REG;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - combinational opcode/funct to op-select, B-select and shift-source map
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    op,
    output bsel_e      bsel,
    output shsrc_e     shsrc
);

    always_comb begin
        op    = OP_ZERO;
        shsrc = SHSRC_SHAMT;
        bsel  = imm_bsel(opcode);
        case (opcode)
            OPC_R: begin
                case (funct)
                    FN_SLL:          op = OP_SLL;
                    FN_SRL:          op = OP_SRL;
                    FN_SRA:          op = OP_SRA;
                    FN_SLLV: begin   op = OP_SLL; shsrc = SHSRC_RS; end
                    FN_SRLV: begin   op = OP_SRL; shsrc = SHSRC_RS; end
                    FN_SRAV: begin   op = OP_SRA; shsrc = SHSRC_RS; end
                    FN_ADD, FN_ADDU: op = OP_ADD;
                    FN_SUB, FN_SUBU: op = OP_SUB;
                    FN_AND:          op = OP_AND;
                    FN_OR:           op = OP_OR;
                    FN_XOR:          op = OP_XOR;
                    FN_NOR:          op = OP_NOR;
                    FN_SLT:          op = OP_SLT;
                    FN_SLTU:         op = OP_SLTU;
                    default:         op = OP_ZERO;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: op = OP_ADD;
            OPC_SLTI:                            op = OP_SLT;
            OPC_SLTIU:                           op = OP_SLTU;
            OPC_ANDI:                            op = OP_AND;
            OPC_ORI:                             op = OP_OR;
            OPC_XORI:                            op = OP_XOR;
            OPC_LUI:                             op = OP_LUI;
            default:                             op = OP_ZERO;
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - registered 32-bit EX-stage ALU; MIPS_ALU_PREDECODE_EN moves op decode to the ID stage
module mips_alu
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode_fwd,
    input  logic [5:0]  funct_fwd,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rrs,
    input  logic [31:0] rrt_in,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt_in,
    output logic [31:0] rslt
);

    alu_op_e op;
    shsrc_e  shsrc;
    bsel_e   bsel;

`ifdef MIPS_ALU_PREDECODE_EN
    alu_op_e  op_fwd;
    shsrc_e   shsrc_fwd;
    bsel_e    unused_bsel_fwd;
    alu_sel_t sel_d;
    alu_sel_t sel_q;
    logic     unused_funct;

    assign unused_funct = ^funct;

    mips_alu_decode u_decode (
        .opcode (opcode_fwd),
        .funct  (funct_fwd),
        .op     (op_fwd),
        .bsel   (unused_bsel_fwd),
        .shsrc  (shsrc_fwd)
    );

    always_comb begin
        sel_d = '{op: op_fwd, shsrc: shsrc_fwd};
    end

    // Captured every edge: a non-stalling pipeline guarantees the ID instruction is next in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= SEL_ZERO;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign op    = sel_q.op;
    assign shsrc = sel_q.shsrc;
    assign bsel  = imm_bsel(opcode);
`else
    logic unused_fwd;

    assign unused_fwd = ^{opcode_fwd, funct_fwd};

    mips_alu_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .op     (op),
        .bsel   (bsel),
        .shsrc  (shsrc)
    );
`endif

    logic [31:0] opb;
    logic [4:0]  sh;
    logic [31:0] rslt_d;
    logic [31:0] rslt_q;

    always_comb begin
        case (bsel)
            BSEL_SEXT: opb = {{16{imm[15]}}, imm};
            BSEL_ZEXT: opb = {16'h0000, imm};
            default:   opb = rrt_in;
        endcase
        sh = (shsrc == SHSRC_RS) ? rrs[4:0] : shamt_in;
    end

    always_comb begin
        rslt_d = 32'd0;
        case (op)
            OP_ADD:  rslt_d = rrs + opb;
            OP_SUB:  rslt_d = rrs - opb;
            OP_AND:  rslt_d = rrs & opb;
            OP_OR:   rslt_d = rrs | opb;
            OP_XOR:  rslt_d = rrs ^ opb;
            OP_NOR:  rslt_d = ~(rrs | opb);
            OP_SLT:  rslt_d = {31'd0, $signed(rrs) < $signed(opb)};
            OP_SLTU: rslt_d = {31'd0, rrs < opb};
            OP_SLL:  rslt_d = rrt_in << sh;
            OP_SRL:  rslt_d = rrt_in >> sh;
            OP_SRA:  rslt_d = $signed(rrt_in) >>> sh;
            OP_LUI:  rslt_d = {imm, 16'h0000};
            default: rslt_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rslt_q <= 32'd0;
        end else begin
            rslt_q <= rslt_d;
        end
    end

    assign rslt = rslt_q;

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - directed-vector bench for mips_alu with a spec-level result model
module tb_mips_alu;

`ifdef MIPS_ALU_PREDECODE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode_fwd, funct_fwd, opcode, funct;
    logic [31:0] rrs, rrt_in;
    logic [15:0] imm;
    logic [4:0]  shamt_in;
    logic [31:0] rslt;

    always #5 clk = ~clk;

    mips_alu dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_fwd (opcode_fwd),
        .funct_fwd  (funct_fwd),
        .opcode     (opcode),
        .funct      (funct),
        .rrs        (rrs),
        .rrt_in     (rrt_in),
        .imm        (imm),
        .shamt_in   (shamt_in),
        .rslt       (rslt)
    );

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t        vq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_exp = 32'd0;

    function automatic logic [31:0] model(input logic [5:0] opc, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] im, input logic [4:0] sh);
        logic [31:0] se, ze, r;
        se = {{16{im[15]}}, im};
        ze = {16'h0000, im};
        r  = 32'd0;
        if (opc == 6'd0) begin
            case (fn)
                6'd0:         r = b << sh;
                6'd2:         r = b >> sh;
                6'd3:         r = $signed(b) >>> sh;
                6'd4:         r = b << a[4:0];
                6'd6:         r = b >> a[4:0];
                6'd7:         r = $signed(b) >>> a[4:0];
                6'd32, 6'd33: r = a + b;
                6'd34, 6'd35: r = a - b;
                6'd36:        r = a & b;
                6'd37:        r = a | b;
                6'd38:        r = a ^ b;
                6'd39:        r = ~(a | b);
                6'd42:        r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'd43:        r = (a < b) ? 32'd1 : 32'd0;
                default:      r = 32'd0;
            endcase
        end else begin
            case (opc)
                6'd8, 6'd9, 6'd35, 6'd43: r = a + se;
                6'd10:   r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                6'd11:   r = (a < se) ? 32'd1 : 32'd0;
                6'd12:   r = a & ze;
                6'd13:   r = a | ze;
                6'd14:   r = a ^ ze;
                6'd15:   r = {im, 16'h0000};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    task automatic add(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] im, input logic [4:0] sh,
                       input logic [31:0] exp);
        vec_t v;
        v.opc = opc; v.fn = fn; v.a = a; v.b = b; v.imm = im; v.sh = sh; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: rslt=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: inputs seen at an edge determine rslt just after that edge.
    initial begin
        bit          prev_rst;
        bit          r;
        int          cyc;
        logic [5:0]  c_opc, c_fn;
        logic [31:0] c_a, c_b, c_lit, exp;
        logic [15:0] c_imm;
        logic [4:0]  c_sh;
        bit          post_rst_zero;
        prev_rst = 1'b0;
        cyc      = 0;
        forever begin
            @(posedge clk);
            r = rst; c_opc = opcode; c_fn = funct; c_a = rrs; c_b = rrt_in;
            c_imm = imm; c_sh = shamt_in; c_lit = cur_exp;
            #1;
            post_rst_zero = PRE && prev_rst;
            if (r || post_rst_zero) exp = 32'd0;
            else                    exp = model(c_opc, c_fn, c_a, c_b, c_imm, c_sh);
            check("model", cyc, rslt, exp);
            if (!r && !post_rst_zero) check("literal", cyc, rslt, c_lit);
            prev_rst = r;
            cyc++;
        end
    end

    task automatic drive(input vec_t ex, input vec_t fw);
        opcode     = ex.opc;
        funct      = ex.fn;
        rrs        = ex.a;
        rrt_in     = ex.b;
        imm        = ex.imm;
        shamt_in   = ex.sh;
        cur_exp    = ex.exp;
        opcode_fwd = fw.opc;
        funct_fwd  = fw.fn;
    endtask

    localparam int RST_IDX = 18;

    initial begin
        vec_t z;
        z.opc = 6'd0; z.fn = 6'd0; z.a = 32'd0; z.b = 32'd0; z.imm = 16'd0; z.sh = 5'd0; z.exp = 32'd0;

        add(6'd0,  6'd33, 32'h7FFF_FFFF, 32'h1,         16'h0,    5'd0,  32'h8000_0000);
        add(6'd0,  6'd32, 32'h7FFF_FFFF, 32'h1,         16'h0,    5'd0,  32'h8000_0000);
        add(6'd0,  6'd35, 32'h0,         32'h1,         16'h0,    5'd0,  32'hFFFF_FFFF);
        add(6'd10, 6'd0,  32'hFFFF_FFFF, 32'h0,         16'h0001, 5'd0,  32'h1);
        add(6'd11, 6'd0,  32'hFFFF_FFFF, 32'h0,         16'h0001, 5'd0,  32'h0);
        add(6'd12, 6'd0,  32'hFFFF_FFFF, 32'h0,         16'h8000, 5'd0,  32'h0000_8000);
        add(6'd0,  6'd3,  32'h0,         32'h8000_0000, 16'h0,    5'd4,  32'hF800_0000);
        add(6'd0,  6'd6,  32'd36,        32'h8000_0000, 16'h0,    5'd0,  32'h0800_0000);
        add(6'd15, 6'd0,  32'h55,        32'h0,         16'h1234, 5'd0,  32'h1234_0000);
        add(6'd35, 6'd0,  32'h100,       32'h0,         16'hFFFC, 5'd0,  32'h0000_00FC);
        add(6'd0,  6'd33, 32'd5,         32'd7,         16'h0,    5'd0,  32'hC);
        add(6'd0,  6'd0,  32'h0,         32'h3,         16'h0,    5'd4,  32'h30);
        add(6'd13, 6'd0,  32'hF0,        32'h0,         16'h0F0F, 5'd0,  32'h0FFF);
        add(6'd43, 6'd0,  32'h1000,      32'h0,         16'h0010, 5'd0,  32'h1010);
        add(6'd4,  6'd0,  32'h5,         32'h5,         16'h0003, 5'd0,  32'h0);
        add(6'd0,  6'd42, 32'hFFFF_FFFF, 32'h1,         16'h0,    5'd0,  32'h1);
        add(6'd0,  6'd43, 32'hFFFF_FFFF, 32'h1,         16'h0,    5'd0,  32'h0);
        add(6'd0,  6'd39, 32'h0,         32'h0,         16'h0,    5'd0,  32'hFFFF_FFFF);
        add(6'd0,  6'd33, 32'd1,         32'd1,         16'h0,    5'd0,  32'h2);
        add(6'd0,  6'd35, 32'd10,        32'd3,         16'h0,    5'd0,  32'h7);
        add(6'd14, 6'd0,  32'hFFFF_0000, 32'h0,         16'hFFFF, 5'd0,  32'hFFFF_FFFF);
        add(6'd8,  6'd0,  32'h0,         32'h0,         16'hFFFF, 5'd0,  32'hFFFF_FFFF);
        add(6'd0,  6'd7,  32'd33,        32'h8000_0000, 16'h0,    5'd0,  32'hC000_0000);
        add(6'd0,  6'd4,  32'd31,        32'h1,         16'h0,    5'd0,  32'h8000_0000);
        add(6'd0,  6'd2,  32'h0,         32'h8000_0000, 16'h0,    5'd31, 32'h1);
        add(6'd0,  6'd1,  32'hFF,        32'hFF,        16'h0,    5'd0,  32'h0);
        add(6'd2,  6'd0,  32'hFF,        32'hFF,        16'hFFFF, 5'd0,  32'h0);
        add(6'd0,  6'd36, 32'hF0F0,      32'hFF00,      16'h0,    5'd0,  32'hF000);
        add(6'd0,  6'd38, 32'hFFFF,      32'h0F0F,      16'h0,    5'd0,  32'hF0F0);
        add(6'd10, 6'd0,  32'd5,         32'h0,         16'hFFFF, 5'd0,  32'h0);
        add(6'd0,  6'd34, 32'd5,         32'd7,         16'h0,    5'd0,  32'hFFFF_FFFE);
        add(6'd5,  6'd0,  32'h1,         32'h2,         16'h0004, 5'd0,  32'h0);

        rst = 1'b1;
        drive(z, vq[0]);
        repeat (2) @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            rst = (i == RST_IDX);
            drive(vq[i], (i + 1 < vq.size()) ? vq[i + 1] : z);
            @(negedge clk);
        end
        rst = 1'b0;
        drive(z, z);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
